texture_bank: RTL and testbench

//  GPU texture store holding NUM_TEXTURES textures of TEXTURE_SIZE texels each.
//  CPU side is an AXI4-Lite write slave with error responses. Rasteriser side has
//  NUM_PORTS independent 1-cycle read ports, used for parallel pixel fetch.

---
 rtl/texture_bank.sv | 234 +++++++++++++++++++++++
 tb/tb_texture_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_bank.sv
// texture_bank: texel store for NUM_TEXTURES textures with an AXI4-Lite write slave and
// NUM_PORTS registered rasteriser read ports. Define TEXTURE_BANK_READBACK_EN to add an AXI4-Lite read slave.
module texture_bank #(
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 32,
    parameter int COLOR_WIDTH  = 12,
    parameter int TEXTURE_SIZE = 4096,
    parameter int NUM_TEXTURES = 8,
    parameter int NUM_PORTS    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            awaddr,
    input  logic [2:0]                       awprot,
    input  logic                             awvalid,
    output logic                             awready,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/8-1:0]          wstrb,
    input  logic                             wvalid,
    output logic                             wready,
    output logic [1:0]                       bresp,
    output logic                             bvalid,
    input  logic                             bready,
`ifdef TEXTURE_BANK_READBACK_EN
    input  logic [ADDR_WIDTH-1:0]            araddr,
    input  logic [2:0]                       arprot,
    input  logic                             arvalid,
    output logic                             arready,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [1:0]                       rresp,
    output logic                             rvalid,
    input  logic                             rready,
`endif
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  raddr,
    output logic [NUM_PORTS*COLOR_WIDTH-1:0] rcolor
);
    localparam int DEPTH = NUM_TEXTURES * TEXTURE_SIZE;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    if (ADDR_WIDTH < IDX_W || DATA_WIDTH < COLOR_WIDTH) begin : g_param_check
        $error("texture_bank: ADDR_WIDTH too small for DEPTH or DATA_WIDTH < COLOR_WIDTH");
    end

    // Range test is done on the full address so out-of-range indices never alias.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a < DEPTH_A;
    endfunction

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_RESP = 2'd2} w_state_e;

    logic [COLOR_WIDTH-1:0] mem [DEPTH];

    w_state_e                   w_state_q, w_state_d;
    logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]      awaddr_q, awaddr_d;
    logic [COLOR_WIDTH-1:0]     wtexel_q, wtexel_d;
    logic                       awready_q, awready_d, wready_q, wready_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [NUM_PORTS*COLOR_WIDTH-1:0] rcolor_q, rcolor_d;
    logic                       aw_fire_s, w_fire_s, b_fire_s, mem_we_s;
    logic                       unused_s;

    // Write-side state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wtexel_q  <= {COLOR_WIDTH{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rcolor_q  <= {(NUM_PORTS*COLOR_WIDTH){1'b0}};
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wtexel_q  <= wtexel_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rcolor_q  <= rcolor_d;
        end
    end

    // Texel memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[awaddr_q[IDX_W-1:0]] <= wtexel_q;
        end
    end

    // AW/W capture, memory write enable and response code
    always_comb begin
        aw_fire_s = (w_state_q == W_IDLE) && awvalid && awready_q;
        w_fire_s  = (w_state_q == W_IDLE) && wvalid && wready_q;
        b_fire_s  = (w_state_q == W_RESP) && bvalid_q && bready;
        mem_we_s  = (w_state_q == W_WRITE) && in_range(awaddr_q);
        aw_held_d = b_fire_s ? 1'b0 : (aw_held_q | aw_fire_s);
        w_held_d  = b_fire_s ? 1'b0 : (w_held_q | w_fire_s);
        awaddr_d  = aw_fire_s ? awaddr : awaddr_q;
        wtexel_d  = w_fire_s ? wdata[COLOR_WIDTH-1:0] : wtexel_q;
        if (w_state_q == W_WRITE) begin
            bresp_d = in_range(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            bresp_d = bresp_q;
        end
    end

    // Write FSM next state
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_WRITE;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_WRITE: w_state_d = W_RESP;
            W_RESP: begin
                if (b_fire_s) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Handshake outputs for the next cycle; bvalid trails entry into W_RESP by one edge
    always_comb begin
        awready_d = ((w_state_q == W_IDLE) && !aw_held_d) || b_fire_s;
        wready_d  = ((w_state_q == W_IDLE) && !w_held_d) || b_fire_s;
        bvalid_d  = (w_state_q == W_RESP) && !b_fire_s;
    end

    // Rasteriser read ports; read-first against a same-edge write
    always_comb begin
        rcolor_d = {(NUM_PORTS*COLOR_WIDTH){1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (in_range(raddr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rcolor_d[p*COLOR_WIDTH +: COLOR_WIDTH] = mem[raddr[p*ADDR_WIDTH +: IDX_W]];
            end else begin
                rcolor_d[p*COLOR_WIDTH +: COLOR_WIDTH] = {COLOR_WIDTH{1'b0}};
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rcolor  = rcolor_q;

`ifdef TEXTURE_BANK_READBACK_EN
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic                   arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   ar_fire_s, r_fire_s, r_load_s;

    // Read-slave state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= {ADDR_WIDTH{1'b0}};
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read-slave next state
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  r_state_d = ar_fire_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_d = r_fire_s ? R_IDLE : R_DATA;
            default: r_state_d = R_IDLE;
        endcase
    end

    // The first R_DATA cycle fetches the texel; afterwards the beat is held until rready
    always_comb begin
        ar_fire_s = (r_state_q == R_IDLE) && arvalid && arready_q;
        r_fire_s  = (r_state_q == R_DATA) && rvalid_q && rready;
        r_load_s  = (r_state_q == R_DATA) && !rvalid_q;
        araddr_d  = ar_fire_s ? araddr : araddr_q;
        arready_d = ((r_state_q == R_IDLE) && !ar_fire_s) || r_fire_s;
        rvalid_d  = r_load_s || (rvalid_q && !rready);
        if (r_load_s && in_range(araddr_q)) begin
            rdata_d = {{(DATA_WIDTH-COLOR_WIDTH){1'b0}}, mem[araddr_q[IDX_W-1:0]]};
            rresp_d = RESP_OKAY;
        end else if (r_load_s) begin
            rdata_d = {DATA_WIDTH{1'b0}};
            rresp_d = RESP_SLVERR;
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
    end

    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign unused_s = ^{awprot, wstrb, wdata, arprot};
`else
    assign unused_s = ^{awprot, wstrb, wdata};
`endif

endmodule

// File: tb/tb_texture_bank.sv
// Self-checking bench for texture_bank: directed scenarios plus randomized writes/reads
// checked against an associative-array texel model.
module tb_texture_bank;
    localparam int AW    = 22;
    localparam int DW    = 32;
    localparam int CW    = 12;
    localparam int NP    = 2;
    localparam int DEPTH = 8 * 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [NP*AW-1:0]  raddr;
    logic [NP*CW-1:0]  rcolor;
`ifdef TEXTURE_BANK_READBACK_EN
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid, arready, rvalid, rready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
`endif

    always #5 clk = ~clk;

    texture_bank dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef TEXTURE_BANK_READBACK_EN
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
`endif
        .raddr(raddr), .rcolor(rcolor)
    );

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] model [int];
    int written[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a write lands only inside the texture store; everything else is SLVERR.
    function automatic logic [1:0] ref_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        if (int'(a) < DEPTH) begin
            model[int'(a)] = d;
            return 2'd0;
        end
        return 2'd2;
    endfunction

    function automatic logic [CW-1:0] ref_read(input logic [AW-1:0] a);
        if (int'(a) < DEPTH && model.exists(int'(a))) return model[int'(a)];
        return 12'h000;
    endfunction

    // Full write transaction, called and returning at a negedge.
    task automatic axi_write(input logic [AW-1:0] a, input logic [CW-1:0] d, input int aw_dly,
                             input int w_dly, input int b_dly, output logic [1:0] resp, output int lat);
        bit aw_done = 1'b0, w_done = 1'b0, aw_f, w_f;
        int cyc = 0;
        logic [1:0] r0;
        awprot = 3'($urandom);
        wstrb  = 4'($urandom);
        while (!(aw_done && w_done) && cyc < 64) begin
            awaddr  = a;
            wdata   = {20'($urandom), d};
            awvalid = !aw_done && cyc >= aw_dly;
            wvalid  = !w_done && cyc >= w_dly;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(negedge clk);
            cyc++;
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            if (w_done) check("wready_low_after_w", 32'(wready), 32'd0);
            if (aw_done) check("awready_low_after_aw", 32'(awready), 32'd0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_accepted", 32'({aw_done, w_done}), 32'd3);
        lat = 0;
        while (!bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("bvalid_seen", 32'(bvalid), 32'd1);
        r0 = bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("bresp_hold", 32'(bresp), 32'(r0));
        end
        bready = 1'b1;
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
        raddr = {a1, a0};
        @(negedge clk);
        check({tag, "_p0"}, 32'(rcolor[0 +: CW]), 32'(ref_read(a0)));
        check({tag, "_p1"}, 32'(rcolor[CW +: CW]), 32'(ref_read(a1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] resp, er;
        int lat, cyc;
        logic [CW-1:0] old0, d;
        logic [AW-1:0] a, a0, a1;

        rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; raddr = '0;
`ifdef TEXTURE_BANK_READBACK_EN
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rcolor", 32'(rcolor), 32'd0);
`ifdef TEXTURE_BANK_READBACK_EN
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_rst", 32'(awready), 32'd1);

        // Same-cycle AW+W, immediate bready
        er = ref_write(22'h10, 12'hABC);
        axi_write(22'h10, 12'hABC, 0, 0, 0, resp, lat);
        check("t1_bresp", 32'(resp), 32'(er));
        check("t1_latency", 32'(lat), 32'd2);
        read2(22'h10, 22'h10, "t1_read");

        // W leads AW by 3 cycles, bready held low 4 cycles
        er = ref_write(22'h20, 12'h123);
        axi_write(22'h20, 12'h123, 3, 0, 4, resp, lat);
        check("t2_bresp", 32'(resp), 32'(er));
        read2(22'h20, 22'h10, "t2_read");

        er = ref_write(22'h0, 12'h111);
        axi_write(22'h0, 12'h111, 0, 1, 0, resp, lat);
        er = ref_write(22'(DEPTH - 1), 12'h777);
        axi_write(22'(DEPTH - 1), 12'h777, 1, 0, 0, resp, lat);
        check("last_bresp", 32'(resp), 32'(er));

        // Out-of-range write must not alias onto texel 0
        er = ref_write(22'(DEPTH), 12'hFFF);
        axi_write(22'(DEPTH), 12'hFFF, 0, 0, 1, resp, lat);
        check("t3_bresp", 32'(resp), 32'd2);
        read2(22'(DEPTH), 22'h0, "t3_read");
        er = ref_write(22'h3FFFFF, 12'hFFF);
        axi_write(22'h3FFFFF, 12'hFFF, 2, 0, 0, resp, lat);
        check("t3_top_bresp", 32'(resp), 32'd2);
        read2(22'h3FFFFF, 22'(DEPTH - 1), "t3_top_read");

        // Read/write collision on texel 0 is read-first
        old0 = ref_read(22'h0);
        awaddr = 22'h0; wdata = {20'($urandom), 12'h4C4}; awvalid = 1'b1; wvalid = 1'b1;
        check("t4_ready", 32'({awready, wready}), 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        raddr = {22'(DEPTH - 1), 22'h0};
        @(negedge clk);
        check("t4_p0_old", 32'(rcolor[0 +: CW]), 32'(old0));
        check("t4_p1", 32'(rcolor[CW +: CW]), 32'h777);
        er = ref_write(22'h0, 12'h4C4);
        @(negedge clk);
        check("t4_p0_new", 32'(rcolor[0 +: CW]), 32'h4C4);
        check("t4_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Reset while waiting in W_RESP; the write itself already committed
        check("t5_awready", 32'(awready), 32'd1);
        awaddr = 22'h30; wdata = {20'($urandom), 12'h3C3}; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_bvalid_before_rst", 32'(bvalid), 32'd1);
        er = ref_write(22'h30, 12'h3C3);
        rst = 1'b1;
        @(negedge clk);
        check("t5_bvalid_rst", 32'(bvalid), 32'd0);
        check("t5_awready_rst", 32'(awready), 32'd0);
        check("t5_rcolor_rst", 32'(rcolor), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        er = ref_write(22'h31, 12'h1E1);
        axi_write(22'h31, 12'h1E1, 1, 0, 1, resp, lat);
        check("t5_fresh_bresp", 32'(resp), 32'(er));
        read2(22'h30, 22'h31, "t5_read");

        // Randomized writes against the model
        written = '{32'h10, 32'h20, 32'h0, DEPTH - 1, 32'h30, 32'h31};
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: a = 22'(DEPTH + $urandom_range(0, 3));
                1: a = 22'(32'h3FFFFF - $urandom_range(0, 2));
                default: a = 22'($urandom_range(0, DEPTH - 1));
            endcase
            d = 12'($urandom);
            er = ref_write(a, d);
            axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, lat);
            check("rand_bresp", 32'(resp), 32'(er));
            check("rand_latency", 32'(lat), 32'd2);
            if (int'(a) < DEPTH) written.push_back(int'(a));
        end
        for (int n = 0; n < 40; n++) begin
            a0 = ($urandom_range(0, 7) == 0) ? 22'(DEPTH + $urandom_range(0, 100))
                                             : 22'(written[$urandom_range(0, written.size() - 1)]);
            a1 = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF
                                             : 22'(written[$urandom_range(0, written.size() - 1)]);
            read2(a0, a1, "rand_read");
        end

`ifdef TEXTURE_BANK_READBACK_EN
        // AXI read-back with rready held low two cycles
        er = ref_write(22'h7, 12'h5A5);
        axi_write(22'h7, 12'h5A5, 0, 0, 0, resp, lat);
        araddr = 22'h7; arprot = 3'($urandom); arvalid = 1'b1;
        check("t6_arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("t6_rvalid_early", 32'(rvalid), 32'd0);
        @(negedge clk);
        check("t6_rvalid", 32'(rvalid), 32'd1);
        check("t6_rdata", rdata, 32'h5A5);
        check("t6_rresp", 32'(rresp), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("t6_rvalid_hold", 32'(rvalid), 32'd1);
            check("t6_rdata_hold", rdata, 32'h5A5);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("t6_rvalid_drop", 32'(rvalid), 32'd0);
        @(negedge clk);
        araddr = 22'(DEPTH); arvalid = 1'b1;
        check("t6_oor_arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        check("t6_oor_rdata", rdata, 32'd0);
        check("t6_oor_rresp", 32'(rresp), 32'd2);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
